// File: rtl/counter_pkg.sv
// Shared encodings for the counter datapath: sequencer states and count direction.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the run clock: tick fires once every (div+1) enabled, non-held cycles.
module tick_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               hold,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_reg;

  assign tick = en && !hold && (presc_reg == div);

  // Disabled clears, hold freezes so a paused count resumes mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (!en) begin
      presc_reg <= '0;
    end else if (!hold) begin
      if (tick) presc_reg <= '0;
      else      presc_reg <= presc_reg + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run-control sequencer: config handshake, start/stop/clear FSM and the count register.
module count_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic               cfg_down,
  input  logic [PRESC_W-1:0] cfg_div,
  input  logic               cfg_reload,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  output logic [WIDTH-1:0]   count,
  output logic               tick,
  output logic               wrap,
  output logic               done,
  output logic               busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   count_reg, count_next;
  logic [WIDTH-1:0]   limit_reg, limit_next;
  logic               down_reg, down_next;
  logic               reload_reg, reload_next;
  logic [PRESC_W-1:0] div_reg, div_next;
  logic               busy_reg, busy_next;
  logic               ready_reg, ready_next;

  logic               cfg_accept;
  logic [WIDTH-1:0]   new_start;
  logic [WIDTH-1:0]   term_val;
  logic               at_term;
  logic               go;
  logic               presc_en;
  logic               presc_hold;
  logic               presc_tick;

  // stop in the RUN cycle itself freezes the prescaler so no step slips through.
  assign presc_en   = ((state_reg == ST_RUN) || (state_reg == ST_PAUSE)) && !clear;
  assign presc_hold = (state_reg == ST_PAUSE) || stop;

  tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .hold (presc_hold),
    .div  (div_reg),
    .tick (presc_tick)
  );

  assign count     = count_reg;
  assign busy      = busy_reg;
  assign cfg_ready = ready_reg;
  assign tick      = presc_tick;
  assign wrap      = presc_tick && at_term && reload_reg;
  assign done      = presc_tick && at_term && !reload_reg;

  always_comb begin
    cfg_accept  = cfg_valid && ready_reg;
    limit_next  = cfg_accept ? cfg_limit  : limit_reg;
    down_next   = cfg_accept ? cfg_down   : down_reg;
    div_next    = cfg_accept ? cfg_div    : div_reg;
    reload_next = cfg_accept ? cfg_reload : reload_reg;
    // Start value of whichever config is in force after this edge.
    new_start   = (down_next == DIR_UP) ? '0 : limit_next;
    term_val    = (down_reg == DIR_DOWN) ? '0 : limit_reg;
    at_term     = (count_reg == term_val);
    go          = start && !stop;

    state_next = state_reg;
    count_next = count_reg;

    if (clear) begin
      state_next = ST_IDLE;
      count_next = new_start;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (go) state_next = ST_RUN;
          if (go || cfg_accept) count_next = new_start;
        end
        ST_RUN: begin
          if (stop) begin
            state_next = ST_PAUSE;
          end else if (presc_tick) begin
            if (!at_term) begin
              count_next = (down_reg == DIR_DOWN) ? count_reg - ONE : count_reg + ONE;
            end else if (reload_reg) begin
              count_next = (down_reg == DIR_DOWN) ? limit_reg : '0;
            end else begin
              state_next = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (go) state_next = ST_RUN;
        end
        default: state_next = ST_IDLE;
      endcase
    end

    busy_next  = (state_next == ST_RUN)  || (state_next == ST_PAUSE);
    ready_next = (state_next == ST_IDLE) || (state_next == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      limit_reg  <= '1;
      down_reg   <= DIR_UP;
      div_reg    <= '0;
      reload_reg <= 1'b0;
      busy_reg   <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      limit_reg  <= limit_next;
      down_reg   <= down_next;
      div_reg    <= div_next;
      reload_reg <= reload_next;
      busy_reg   <= busy_next;
      ready_reg  <= ready_next;
    end
  end

endmodule
